// File: rtl/regport_read_arbiter.sv
// Four-way arbiter for a single 32x32 register-file read port: grant, read, respond in 3 cycles.
// Build option REGPORT_ARB_FIXED_PRIO_EN selects fixed priority (req[0] highest) instead of round-robin.
module regport_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [ADDR_WIDTH-1:0] req_addr2,
  input  logic [ADDR_WIDTH-1:0] req_addr3,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    rsp_valid_q;
  logic [1:0]              rsp_id_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    busy_q;
  logic [1:0]              win_d;
  logic [ADDR_WIDTH-1:0]   addr_d;

  // First set bit at or above p, wrapping 3->0; caller guarantees r is non-zero.
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    pick_rr = 2'd0;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        pick_rr = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Lowest set bit wins.
  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    if (r[0])      pick_fixed = 2'd0;
    else if (r[1]) pick_fixed = 2'd1;
    else if (r[2]) pick_fixed = 2'd2;
    else           pick_fixed = 2'd3;
  endfunction

`ifdef REGPORT_ARB_FIXED_PRIO_EN
  // Winner selection, fixed priority.
  always_comb begin
    win_d = pick_fixed(req);
  end
`else
  logic [1:0] ptr_q;

  // Winner selection, round-robin from ptr_q.
  always_comb begin
    win_d = pick_rr(req, ptr_q);
  end
`endif

  // Address of the winning requester.
  always_comb begin
    case (win_d)
      2'd0:    addr_d = req_addr0;
      2'd1:    addr_d = req_addr1;
      2'd2:    addr_d = req_addr2;
      2'd3:    addr_d = req_addr3;
      default: addr_d = req_addr0;
    endcase
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= {NUM_REQ{1'b0}};
      rd_addr_q   <= {ADDR_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      rsp_data_q  <= {DATA_WIDTH{1'b0}};
      busy_q      <= 1'b0;
`ifndef REGPORT_ARB_FIXED_PRIO_EN
      ptr_q       <= 2'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_d;
            rd_addr_q <= addr_d;
            rsp_id_q  <= win_d;
            busy_q    <= 1'b1;
            state_q   <= READ;
`ifndef REGPORT_ARB_FIXED_PRIO_EN
            ptr_q     <= win_d + 2'd1;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        READ: begin
          rsp_data_q  <= rd_data;
          rsp_valid_q <= 1'b1;
          gnt_q       <= {NUM_REQ{1'b0}};
          state_q     <= RESP;
        end
        RESP: begin
          // rd_addr, rsp_id and rsp_data deliberately hold past this point.
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          gnt_q       <= {NUM_REQ{1'b0}};
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rd_addr   = rd_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule
